// File: rtl/blank_scheduler.sv
// Raster-driven blank scheduler feeding the ISO blank mapper (ACTIVE/BS/START/BLANK/BE per line).
// Optional macro BLANK_SCHED_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module blank_scheduler #(
  parameter int H_W = 16,
  parameter int V_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           td_vid_en,
  input  logic [1:0]     td_lane_count,
  input  logic [H_W-1:0] td_h_total,
  input  logic [H_W-1:0] td_h_active,
  input  logic [V_W-1:0] td_v_total,
  input  logic [V_W-1:0] td_v_active,
  output logic           sched_blank_en,
  output logic           sched_blank_id,
  output logic [1:0]     sched_blank_state,
  output logic           sched_video_en,
`ifdef BLANK_SCHED_FRAME_CNT_EN
  output logic [15:0]    sched_frame_cnt,
`endif
  output logic           sched_cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  localparam logic [1:0] CODE_BLANK = 2'b00;
  localparam logic [1:0] CODE_BS    = 2'b01;
  localparam logic [1:0] CODE_START = 2'b10;
  localparam logic [1:0] CODE_BE    = 2'b11;

  localparam logic [H_W-1:0] H_ONE = {{(H_W-1){1'b0}}, 1'b1};
  localparam logic [V_W-1:0] V_ONE = {{(V_W-1){1'b0}}, 1'b1};

  // START symbol length by lane count; the reserved code behaves as 4 lanes.
  function automatic logic [4:0] start_len(input logic [1:0] lanes);
    logic [4:0] len;
    case (lanes)
      2'b00:   len = 5'd12;
      2'b01:   len = 5'd6;
      default: len = 5'd3;
    endcase
    return len;
  endfunction

  state_t         st_r;
  logic [H_W-1:0] h_r;
  logic [V_W-1:0] v_r;
  logic [1:0]     lane_r;
  logic [H_W-1:0] h_total_r;
  logic [H_W-1:0] h_active_r;
  logic [V_W-1:0] v_total_r;
  logic [V_W-1:0] v_active_r;

  logic [4:0]     ls_s;
  logic [H_W:0]   h_need_s;
  logic [H_W:0]   h_wide_s;
  logic [H_W:0]   bs_end_s;
  logic [H_W:0]   start_end_s;
  logic [H_W:0]   be_start_s;
  logic           cfg_bad_s;
  logic           h_last_s;
  logic           v_last_s;
  logic [V_W-1:0] v_next_s;
  logic           line_act_s;
  logic           next_act_s;
  logic [H_W-1:0] h_adv_s;
  logic [V_W-1:0] v_adv_s;

  logic           dec_en_s;
  logic           dec_id_s;
  logic [1:0]     dec_state_s;
  logic           dec_vid_s;

  // Raster geometry, configuration check and counter advance.
  always_comb begin
    ls_s        = start_len(lane_r);
    h_need_s    = {1'b0, h_active_r} + (H_W+1)'(ls_s) + (H_W+1)'(4'd9);
    h_wide_s    = {1'b0, h_r};
    bs_end_s    = {1'b0, h_active_r} + (H_W+1)'(3'd4);
    start_end_s = bs_end_s + (H_W+1)'(ls_s);
    be_start_s  = {1'b0, h_total_r} - (H_W+1)'(3'd4);
    cfg_bad_s   = ({1'b0, h_total_r} < h_need_s) ||
                  (v_active_r == {V_W{1'b0}}) ||
                  (v_active_r >= v_total_r) ||
                  (h_active_r == {H_W{1'b0}});
    h_last_s    = (h_r == (h_total_r - H_ONE));
    v_last_s    = (v_r == (v_total_r - V_ONE));
    if (v_last_s) begin
      v_next_s = {V_W{1'b0}};
    end else begin
      v_next_s = v_r + V_ONE;
    end
    line_act_s  = (v_r < v_active_r);
    next_act_s  = (v_next_s < v_active_r);
    if (h_last_s) begin
      h_adv_s = {H_W{1'b0}};
      v_adv_s = v_next_s;
    end else begin
      h_adv_s = h_r + H_ONE;
      v_adv_s = v_r;
    end
  end

  // Slot decode; blank id is HBlank only between two active lines.
  always_comb begin
    dec_en_s    = 1'b1;
    dec_id_s    = line_act_s & next_act_s;
    dec_state_s = CODE_BLANK;
    dec_vid_s   = 1'b0;
    if (h_r < h_active_r) begin
      if (line_act_s) begin
        dec_en_s  = 1'b0;
        dec_id_s  = 1'b0;
        dec_vid_s = 1'b1;
      end else begin
        dec_id_s  = 1'b0;
      end
    end else if (h_wide_s < bs_end_s) begin
      dec_state_s = CODE_BS;
    end else if (h_wide_s < start_end_s) begin
      dec_state_s = CODE_START;
    end else if (h_wide_s >= be_start_s) begin
      if (next_act_s) begin
        dec_state_s = CODE_BE;
      end else begin
        dec_state_s = CODE_BLANK;
      end
    end else begin
      dec_state_s = CODE_BLANK;
    end
  end

  // Control FSM: capture on enable, then run or park on a bad configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r              <= ST_IDLE;
      h_r               <= {H_W{1'b0}};
      v_r               <= {V_W{1'b0}};
      lane_r            <= 2'b00;
      h_total_r         <= {H_W{1'b0}};
      h_active_r        <= {H_W{1'b0}};
      v_total_r         <= {V_W{1'b0}};
      v_active_r        <= {V_W{1'b0}};
      sched_blank_en    <= 1'b0;
      sched_blank_id    <= 1'b0;
      sched_blank_state <= 2'b00;
      sched_video_en    <= 1'b0;
      sched_cfg_err     <= 1'b0;
    end else if (!td_vid_en) begin
      st_r              <= ST_IDLE;
      h_r               <= {H_W{1'b0}};
      v_r               <= {V_W{1'b0}};
      sched_blank_en    <= 1'b0;
      sched_blank_id    <= 1'b0;
      sched_blank_state <= 2'b00;
      sched_video_en    <= 1'b0;
      sched_cfg_err     <= 1'b0;
    end else begin
      case (st_r)
        ST_IDLE: begin
          lane_r            <= td_lane_count;
          h_total_r         <= td_h_total;
          h_active_r        <= td_h_active;
          v_total_r         <= td_v_total;
          v_active_r        <= td_v_active;
          h_r               <= {H_W{1'b0}};
          v_r               <= {V_W{1'b0}};
          sched_blank_en    <= 1'b0;
          sched_blank_id    <= 1'b0;
          sched_blank_state <= 2'b00;
          sched_video_en    <= 1'b0;
          sched_cfg_err     <= 1'b0;
          st_r              <= ST_RUN;
        end
        ST_RUN: begin
          if (cfg_bad_s) begin
            sched_blank_en    <= 1'b0;
            sched_blank_id    <= 1'b0;
            sched_blank_state <= 2'b00;
            sched_video_en    <= 1'b0;
            sched_cfg_err     <= 1'b1;
            st_r              <= ST_ERR;
          end else begin
            sched_blank_en    <= dec_en_s;
            sched_blank_id    <= dec_id_s;
            sched_blank_state <= dec_state_s;
            sched_video_en    <= dec_vid_s;
            sched_cfg_err     <= 1'b0;
            h_r               <= h_adv_s;
            v_r               <= v_adv_s;
          end
        end
        ST_ERR: begin
          sched_blank_en    <= 1'b0;
          sched_blank_id    <= 1'b0;
          sched_blank_state <= 2'b00;
          sched_video_en    <= 1'b0;
          sched_cfg_err     <= 1'b1;
        end
        default: begin
          sched_blank_en    <= 1'b0;
          sched_blank_id    <= 1'b0;
          sched_blank_state <= 2'b00;
          sched_video_en    <= 1'b0;
          sched_cfg_err     <= 1'b0;
          st_r              <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BLANK_SCHED_FRAME_CNT_EN
  logic wrap_s;
  logic wrap_r;

  assign wrap_s = (st_r == ST_RUN) && !cfg_bad_s && h_last_s && v_last_s;

  // Frame counter steps one cycle after the raster wraps, in line with the (0,0) decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_r          <= 1'b0;
      sched_frame_cnt <= 16'd0;
    end else if (!td_vid_en) begin
      wrap_r          <= 1'b0;
      sched_frame_cnt <= 16'd0;
    end else begin
      wrap_r          <= wrap_s;
      sched_frame_cnt <= sched_frame_cnt + {15'd0, wrap_r};
    end
  end
`endif

endmodule
